// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_SKID
  } skid_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter used for the optional pipeline statistics.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock__i,
  input  logic             reset_n__i,
  input  logic             clear__i,
  input  logic             inc__i,
  output logic [WIDTH-1:0] count__o
);

  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      count__o <= '0;
    end else if (clear__i) begin
      count__o <= '0;
    end else if (inc__i && (count__o != '1)) begin
      count__o <= count__o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and one-entry skid buffer.
// Optional stall/flush counters are built when PIPE_SKID_REG_STATS_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned              DATA_W      = 64,
  parameter logic [DATA_W-1:0]        FLUSH_VALUE = '0
) (
  input  logic                        clock__i,
  input  logic                        reset_n__i,
  input  logic                        flush__i,
  input  logic                        up_valid__i,
  output logic                        up_ready__o,
  input  logic [DATA_W-1:0]           up_data__i,
  output logic                        dn_valid__o,
  input  logic                        dn_ready__i,
  output logic [DATA_W-1:0]           dn_data__o
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [pipe_pkg::STAT_W-1:0] stall_cnt__o,
  output logic [pipe_pkg::STAT_W-1:0] flush_cnt__o
`endif
);

  skid_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q;
  logic              dn_valid_q;
  logic              push;
  logic              pop;

  assign push = up_valid__i & up_ready_q;
  assign pop  = dn_valid_q & dn_ready__i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush__i) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = FLUSH_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_FULL;
            main_d  = up_data__i;
          end
        end
        ST_FULL: begin
          if (push && pop) begin
            main_d = up_data__i;
          end else if (push) begin
            state_d = ST_SKID;
            skid_d  = up_data__i;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the next state into their own flops,
  // so up_ready__o has no combinational path from dn_ready__i.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      state_q    <= ST_EMPTY;
      main_q     <= FLUSH_VALUE;
      skid_q     <= FLUSH_VALUE;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != ST_SKID);
      dn_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign up_ready__o = up_ready_q;
  assign dn_valid__o = dn_valid_q;
  assign dn_data__o  = main_q;

`ifdef PIPE_SKID_REG_STATS_EN
  sat_counter #(
    .WIDTH (pipe_pkg::STAT_W)
  ) u_stall_cnt (
    .clock__i   (clock__i),
    .reset_n__i (reset_n__i),
    .clear__i   (1'b0),
    .inc__i     (dn_valid_q & ~dn_ready__i),
    .count__o   (stall_cnt__o)
  );

  // Counts only flushes that actually discarded a held beat.
  sat_counter #(
    .WIDTH (pipe_pkg::STAT_W)
  ) u_flush_cnt (
    .clock__i   (clock__i),
    .reset_n__i (reset_n__i),
    .clear__i   (1'b0),
    .inc__i     (flush__i & dn_valid_q),
    .count__o   (flush_cnt__o)
  );
`else
  // Default build carries no statistics logic.
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: vector table, corner sequences, random scoreboard.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          flush    = 1'b0;
  logic          up_valid = 1'b0;
  logic          dn_ready = 1'b0;
  logic [DW-1:0] up_data  = '0;
  logic          up_ready;
  logic          dn_valid;
  logic [DW-1:0] dn_data;
`ifdef PIPE_SKID_REG_STATS_EN
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] flush_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [DW-1:0] sb[$];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          f;
    logic          exp_dv;
    logic          exp_ur;
    logic [DW-1:0] exp_dd;
  } vec_t;

  vec_t tbl[16];

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W      (DW),
    .FLUSH_VALUE (64'h0)
  ) dut (
    .clock__i     (clk),
    .reset_n__i   (rst_n),
    .flush__i     (flush),
    .up_valid__i  (up_valid),
    .up_ready__o  (up_ready),
    .up_data__i   (up_data),
    .dn_valid__o  (dn_valid),
    .dn_ready__i  (dn_ready),
    .dn_data__o   (dn_data)
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    .stall_cnt__o (stall_cnt),
    .flush_cnt__o (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic do_push;
    logic do_pop;

    // {valid, data, ready, flush, exp dn_valid, exp up_ready, exp dn_data}
    tbl[0]  = '{1'b1, 64'h11, 1'b1, 1'b0, 1'b1, 1'b1, 64'h11};
    tbl[1]  = '{1'b1, 64'h12, 1'b1, 1'b0, 1'b1, 1'b1, 64'h12};
    tbl[2]  = '{1'b1, 64'h13, 1'b1, 1'b0, 1'b1, 1'b1, 64'h13};
    tbl[3]  = '{1'b1, 64'h14, 1'b1, 1'b0, 1'b1, 1'b1, 64'h14};
    tbl[4]  = '{1'b0, 64'h99, 1'b1, 1'b0, 1'b0, 1'b1, 64'h14};
    tbl[5]  = '{1'b1, 64'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0A};
    tbl[6]  = '{1'b1, 64'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0A};
    tbl[7]  = '{1'b0, 64'h98, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0A};
    tbl[8]  = '{1'b0, 64'h97, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0B};
    tbl[9]  = '{1'b0, 64'h96, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0B};
    tbl[10] = '{1'b1, 64'h21, 1'b0, 1'b0, 1'b1, 1'b1, 64'h21};
    tbl[11] = '{1'b1, 64'h22, 1'b0, 1'b0, 1'b1, 1'b0, 64'h21};
    tbl[12] = '{1'b1, 64'h0C, 1'b0, 1'b1, 1'b0, 1'b1, 64'h00};
    tbl[13] = '{1'b0, 64'h95, 1'b1, 1'b0, 1'b0, 1'b1, 64'h00};
    tbl[14] = '{1'b1, 64'h31, 1'b1, 1'b0, 1'b1, 1'b1, 64'h31};
    tbl[15] = '{1'b1, 64'h32, 1'b1, 1'b1, 1'b0, 1'b1, 64'h00};

    repeat (2) @(posedge clk);
    #1;
    check("rst_dn_valid", {63'b0, dn_valid}, 64'h0);
    check("rst_up_ready", {63'b0, up_ready}, 64'h1);
    check("rst_dn_data", dn_data, 64'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_dn_valid", {63'b0, dn_valid}, 64'h0);
`ifdef PIPE_SKID_REG_STATS_EN
    check("rst_stall_cnt", {48'b0, stall_cnt}, 64'h0);
    check("rst_flush_cnt", {48'b0, flush_cnt}, 64'h0);
`endif

    for (int i = 0; i < 16; i++) begin
      up_valid = tbl[i].v;
      up_data  = tbl[i].d;
      dn_ready = tbl[i].r;
      flush    = tbl[i].f;
      step();
      check($sformatf("vec%0d_dn_valid", i), {63'b0, dn_valid}, {63'b0, tbl[i].exp_dv});
      check($sformatf("vec%0d_up_ready", i), {63'b0, up_ready}, {63'b0, tbl[i].exp_ur});
      check($sformatf("vec%0d_dn_data", i), dn_data, tbl[i].exp_dd);
    end
    flush = 1'b0;
`ifdef PIPE_SKID_REG_STATS_EN
    check("tbl_stall_cnt", {48'b0, stall_cnt}, 64'd4);
    check("tbl_flush_cnt", {48'b0, flush_cnt}, 64'd2);
`endif

    // Asynchronous reset while a beat is held in the main register.
    up_valid = 1'b1;
    up_data  = 64'h41;
    dn_ready = 1'b0;
    step();
    check("pre_arst_dn_valid", {63'b0, dn_valid}, 64'h1);
    check("pre_arst_dn_data", dn_data, 64'h41);
    up_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_dn_valid", {63'b0, dn_valid}, 64'h0);
    check("arst_up_ready", {63'b0, up_ready}, 64'h1);
    check("arst_dn_data", dn_data, 64'h0);
    #2 rst_n = 1'b1;
    step();
    check("arst_rel_dn_valid", {63'b0, dn_valid}, 64'h0);
    check("arst_rel_up_ready", {63'b0, up_ready}, 64'h1);
`ifdef PIPE_SKID_REG_STATS_EN
    check("arst_stall_cnt", {48'b0, stall_cnt}, 64'h0);
`endif

    // Random traffic against the scoreboard; occupancy model predicts the handshake.
    sb.delete();
    for (int c = 0; c < 10000; c++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      up_data  = {$urandom, $urandom};
      dn_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      check("rnd_up_ready", {63'b0, up_ready}, {63'b0, (sb.size() < 2)});
      check("rnd_dn_valid", {63'b0, dn_valid}, {63'b0, (sb.size() != 0)});
      dn_ready = ~dn_ready;
      #1;
      check("rnd_ready_indep", {63'b0, up_ready}, {63'b0, (sb.size() < 2)});
      dn_ready = ~dn_ready;
      #1;
      do_push = up_valid && (sb.size() < 2);
      do_pop  = (sb.size() != 0) && dn_ready;
      if (do_pop) begin
        check("rnd_order", dn_data, sb[0]);
        void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (do_push) sb.push_back(up_data);
      step();
    end

    up_valid = 1'b0;
    flush    = 1'b0;
    dn_ready = 1'b1;
    repeat (2) begin
      if (sb.size() != 0) begin
        check("drain_order", dn_data, sb[0]);
        void'(sb.pop_front());
      end
      step();
    end
    check("drain_dn_valid", {63'b0, dn_valid}, 64'h0);

`ifdef PIPE_SKID_REG_STATS_EN
    up_valid = 1'b1;
    up_data  = 64'h55;
    dn_ready = 1'b0;
    step();
    up_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    check("stall_sat", {48'b0, stall_cnt}, 64'hFFFF);
    check("stall_hold_data", dn_data, 64'h55);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
